// File: rtl/tpram_rd_streamer.sv
// tpram_rd_streamer: walks EFPGA_TPRAM_R_ADDR from base_addr for xfer_len elements (start/abort, busy/done) and streams rd_data_in through a 2-entry out_data/out_valid/out_ready FIFO
module tpram_rd_streamer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        EFPGA_TPRAM_R_CLK,
  input  logic        r_addr_ff_rstn,
  input  logic        start,
  input  logic [11:0] base_addr,
  input  logic [11:0] xfer_len,
  input  logic [1:0]  r_mode,
  input  logic        abort,
  output logic [11:0] EFPGA_TPRAM_R_ADDR,
  input  logic [31:0] rd_data_in,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [11:0] remain, popcnt;
  logic [2:0] inc, occ;
  logic [1:0] cnt, wr_slot;
  logic [31:0] mem1;
  logic inflight, zdone, pop, issue, launch, kill;
  assign pop = out_valid & out_ready;
  assign occ = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == RUN && remain != 12'd0 && occ < 3'(FIFO_DEPTH);
  assign launch = state == IDLE && start && xfer_len != 12'd0;
  assign kill = state != IDLE && abort;
  assign wr_slot = cnt - {1'b0, pop};
  assign out_valid = cnt != 2'd0;
  always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn)
    if (!r_addr_ff_rstn) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = kill ? IDLE :
              state == IDLE ? (launch ? RUN : IDLE) :
              state == RUN ? ((issue && remain == 12'd1) ? DRAIN : RUN) :
              ((pop && popcnt == 12'd1) ? IDLE : DRAIN);
  always_comb begin
    busy = state != IDLE;
    done = zdone | (state == DRAIN && pop && popcnt == 12'd1 && !kill);
  end
  always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn)
    if (!r_addr_ff_rstn) begin
      EFPGA_TPRAM_R_ADDR <= 12'd0;
      remain <= 12'd0;
      popcnt <= 12'd0;
      inc <= 3'd0;
      inflight <= 1'b0;
      zdone <= 1'b0;
      cnt <= 2'd0;
      out_data <= 32'd0;
      mem1 <= 32'd0;
    end else begin
      zdone <= state == IDLE && start && xfer_len == 12'd0;
      inflight <= issue && !kill;
      if (launch) begin
        EFPGA_TPRAM_R_ADDR <= base_addr;
        remain <= xfer_len;
        popcnt <= xfer_len;
        inc <= r_mode == 2'b01 ? 3'd2 : r_mode == 2'b10 ? 3'd1 : 3'd4;
      end else if (issue) begin
        EFPGA_TPRAM_R_ADDR <= EFPGA_TPRAM_R_ADDR + {9'd0, inc};
        remain <= remain - 12'd1;
      end
      if (pop && !kill) popcnt <= popcnt - 12'd1;
      if (kill) cnt <= 2'd0;
      else begin
        cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        if (pop) out_data <= mem1;
        if (inflight && wr_slot == 2'd0) out_data <= rd_data_in;
        if (inflight && wr_slot != 2'd0) mem1 <= rd_data_in;
      end
    end
endmodule

// File: tb/tb_tpram_rd_streamer.sv
// tb_tpram_rd_streamer: table-driven transfers with a data scoreboard plus hand-written zero-length, abort and async-reset sequences
module tb_tpram_rd_streamer;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [11:0] base_addr = 12'd0, xfer_len = 12'd0, addr;
  logic [1:0] r_mode = 2'd0;
  logic [31:0] rd_data = 32'd0, out_data;
  logic out_valid, busy, done;
  logic [31:0] mem [4096];
  logic [11:0] addr_log [64];
  logic [31:0] sb [$];
  int passed = 0, total = 0, done_cnt = 0;
  typedef struct {
    logic [11:0] base, len;
    logic [1:0] mode;
    logic [15:0] pat;
    int s2, ab, first, dcyc, ndone;
  } vec_t;
  vec_t tbl [9];
  tpram_rd_streamer dut (
    .EFPGA_TPRAM_R_CLK(clk), .r_addr_ff_rstn(rstn), .start(start), .base_addr(base_addr),
    .xfer_len(xfer_len), .r_mode(r_mode), .abort(abort), .EFPGA_TPRAM_R_ADDR(addr),
    .rd_data_in(rd_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (rstn) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL pop_unexpected: got %h expected no data", out_data);
        end else chk("pop_data", out_data, sb.pop_front());
      end
      if (done) done_cnt++;
    end
  task automatic run_row(input vec_t v);
    logic [11:0] a = v.base;
    logic [11:0] inc = v.mode == 2'd1 ? 12'd2 : v.mode == 2'd2 ? 12'd1 : 12'd4;
    int first = 0, dc = 0, d0 = done_cnt;
    bit fin = 0;
    for (int i = 0; i < int'(v.len); i++) begin
      sb.push_back(mem[a]);
      a = a + inc;
    end
    base_addr = v.base; xfer_len = v.len; r_mode = v.mode; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      start = c == v.s2;
      if (start) begin base_addr = 12'h800; xfer_len = 12'd2; r_mode = 2'd1; end
      abort = c == v.ab;
      out_ready = c < 3 ? 1'b1 : v.pat[(c - 3) % 16];
      @(negedge clk);
      if (c < 64) addr_log[c] = addr;
      if (out_valid && first == 0) first = c;
      if (done && dc == 0) dc = c;
      if (v.ab != 0 && c == v.ab + 1) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        sb.delete();
        fin = 1;
      end
      if (dc != 0) fin = 1;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    if (!fin) begin
      total++;
      $display("FAIL timeout: got no done expected done for base %h", v.base);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("first_valid_cycle", first, v.first);
    if (v.dcyc != 0) chk("done_cycle", dc, v.dcyc);
    chk("done_count", done_cnt - d0, v.ndone);
    chk("sb_empty", sb.size(), 0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {8'hA5, 4'h0, 12'(i), 8'(~i)};
    for (int k = 0; k < 8; k++) mem[12'h100 + 12'(4 * k)] = 32'(k);
    tbl[0] = '{12'h100, 12'd8, 2'd0, 16'hFFFF, 0, 0, 3, 10, 1};
    tbl[1] = '{12'hFFE, 12'd4, 2'd2, 16'hFFFF, 0, 0, 3, 6, 1};
    tbl[2] = '{12'h200, 12'd6, 2'd0, 16'hFFE9, 0, 0, 3, 0, 1};
    tbl[3] = '{12'h7F0, 12'd5, 2'd1, 16'hFFFF, 0, 0, 3, 7, 1};
    tbl[4] = '{12'hFFC, 12'd3, 2'd3, 16'hFFFF, 0, 0, 3, 5, 1};
    tbl[5] = '{12'h500, 12'd6, 2'd0, 16'hFFFF, 2, 0, 3, 8, 1};
    tbl[6] = '{12'h300, 12'd16, 2'd0, 16'hFFFF, 0, 7, 3, 0, 0};
    tbl[7] = '{12'h0F8, 12'd10, 2'd2, 16'h5A5A, 0, 0, 3, 0, 1};
    tbl[8] = '{12'h123, 12'd1, 2'd0, 16'hFFFF, 0, 0, 3, 3, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      run_row(tbl[i]);
      if (tbl[i].base == 12'hFFE) begin
        chk("wrap_addr1", 32'(addr_log[1]), 32'hFFE);
        chk("wrap_addr2", 32'(addr_log[2]), 32'hFFF);
        chk("wrap_addr3", 32'(addr_log[3]), 32'h000);
        chk("wrap_addr4", 32'(addr_log[4]), 32'h001);
      end
      @(posedge clk); #1;
    end
    xfer_len = 12'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_once", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    base_addr = 12'h400; xfer_len = 12'd10; r_mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back(mem[12'h400 + 12'(4 * k)]);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    sb.delete();
    chk("arst_addr", 32'(addr), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_row(tbl[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tpram_rd_streamer.md
# tpram_rd_streamer

Read-port sequencer for the eFPGA TPRAM: on a start pulse it walks the TPRAM read address from a base address for a programmed element count and streams the returned 32-bit read data to a consumer with valid/ready flow control. It sits directly upstream of the TPRAM read port and drives `EFPGA_TPRAM_R_ADDR`. It consumes `TPRAM_EFPGA_R_DATA` one cycle after each address. A 2-entry output FIFO absorbs consumer backpressure without losing in-flight reads.

## Interface
- `FIFO_DEPTH`, default 2: output FIFO entries. Fixed at 2 in this revision.
- `EFPGA_TPRAM_R_CLK`  in  1  read-port clock; all state on rising edge.
- `r_addr_ff_rstn`  in  1  reset: asynchronous, active-low, on clock `EFPGA_TPRAM_R_CLK`.
- `start`  in  1  one-cycle pulse; ignored while `busy`=1.
- `base_addr`  in  12  first byte address, sampled on `start`.
- `xfer_len`  in  12  element count, sampled on `start`; 0 = empty transfer.
- `r_mode`  in  2  element size, sampled on `start`; 00 = 4 B, 01 = 2 B, 10 = 1 B, 11 = 4 B.
- `abort`  in  1  level; cancels the transfer.
- `EFPGA_TPRAM_R_ADDR`  out  12  registered read address to the TPRAM.
- `rd_data_in`  in  32  `TPRAM_EFPGA_R_DATA`; valid the cycle after an address is issued.
- `out_data`  out  32  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accept; a pop occurs when `out_valid & out_ready`.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when the last element is popped, or one cycle after a start with `xfer_len`=0.

## Operation
- Reset values: `EFPGA_TPRAM_R_ADDR`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. Reset also clears the FIFO, counters, `inflight` and the state register (IDLE).
- **IDLE → RUN**: on `start` with `xfer_len`≠0. Load `EFPGA_TPRAM_R_ADDR`=`base_addr`, `remain`=`xfer_len`, `inc` = 4 / 2 / 1 / 4 per `r_mode`. Load `popcnt`=`xfer_len`.
- **Zero-length start**: `start` with `xfer_len`=0 pulses `done` the next cycle and stays in IDLE.
- **Issue condition**: state=RUN, `remain`≠0, and (`fifo_count` + `inflight` − `pop`) < 2.
- **On issue**: `EFPGA_TPRAM_R_ADDR` += `inc`, modulo 4096 (wrap 0xFFC+4 → 0x000). `remain` decrements. `inflight` is set to 1 for the next cycle; otherwise `inflight` is set to 0.
- **No issue**: `EFPGA_TPRAM_R_ADDR` holds. The RAM re-reads the same address, which is harmless because the data is not captured.
- **Capture**: when `inflight`=1, push `rd_data_in` to the FIFO. A push and a pop in the same cycle are both performed.
- **Alignment**: addresses are not realigned. Byte/halfword lane rotation is the TPRAM read wrapper's job.
- **RUN → DRAIN**: when `remain` reaches 0.
- **DRAIN → IDLE**: on the pop that takes `popcnt` to 0. `done` pulses in the same cycle as the transition.
- **Abort**: `abort`=1 in RUN or DRAIN, at the next edge:
  - state → IDLE;
  - FIFO flushed, so `out_valid`=0;
  - `inflight` cleared and its data dropped;
  - no `done` pulse.
- **Abort priority**: `abort` takes priority over a simultaneous pop, push or `start`. In IDLE, `abort` has no effect.
- **Reset mid-transfer**: asynchronously returns all state to the reset values. No `done` pulse.

## Timing
- `start` sampled at edge 0. The address is on the bus during cycle 1 and is issued at edge 1. Data is captured at edge 2, and `out_valid`=1 in cycle 2+1.
- First-data latency: 3 cycles from `start`.
- With `out_ready` held at 1, the block sustains one element per cycle. The last element appears at cycle `xfer_len`+2. `done` is asserted in the cycle of the final pop.
- When `out_ready` deasserts, at most 2 elements are held: 1 in the FIFO plus 1 in flight, then the FIFO fills. Issue stalls within 1 cycle and no data is lost.
- `out_data` and `out_valid` are registered, with no combinational path from `out_ready` to them. `out_ready` → issue is combinational through the credit check.

## Test plan
- **Basic dword stream**: memory word at 0x100+4k = k, `base_addr`=0x100, `r_mode`=00, `xfer_len`=8, `out_ready`=1. Expect data 0..7 on consecutive cycles, first at cycle 3, and `done` with the 8th pop.
- **Byte mode and wrap**: `base_addr`=0xFFE, `r_mode`=10, `xfer_len`=4. Expect `EFPGA_TPRAM_R_ADDR` sequence 0xFFE, 0xFFF, 0x000, 0x001. Expect 4 pops, then `done`.
- **Backpressure**: `xfer_len`=6, `out_ready` toggled 1,0,0,1,0,1,1,1…. Expect all 6 values in order with no duplicates. `fifo_count` never exceeds 2. Expect `done` exactly once.
- **Zero length / busy start**: `start` with `xfer_len`=0 gives `done` at +1 and `busy` stays 0. A second `start` during RUN is ignored; parameters are unchanged.
- **Abort mid-stream**: `xfer_len`=16, `abort` at the 5th output cycle. Next cycle: `busy`=0, `out_valid`=0, no `done`. A following `start` runs a clean transfer.
- **Async reset**: deassert `r_addr_ff_rstn` mid-RUN, between edges. Outputs go to reset values immediately, and a new transfer works after release.
